// File: rtl/onchip_memory_pkg.sv
// Shared types and elaboration helpers for the dual-port on-chip RAM.
package onchip_memory_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 2;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit read_latency_ok(input int unsigned lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/onchip_memory_rdpipe.sv
// Per-port read return pipeline: one or two register stages with a matching valid.
module onchip_memory_rdpipe
    import onchip_memory_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              accept,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    logic              v0;
    logic [DATA_W-1:0] d0;

    // Array output register; data only moves with a valid so readdata holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v0 <= 1'b0;
            d0 <= '0;
        end else if (clken) begin
            v0 <= accept;
            if (accept) begin
                d0 <= ram_data;
            end
        end
    end

    if (READ_LATENCY > 1) begin : g_lat2
        logic              v1;
        logic [DATA_W-1:0] d1;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v1 <= 1'b0;
                d1 <= '0;
            end else if (clken) begin
                v1 <= v0;
                if (v0) begin
                    d1 <= d0;
                end
            end
        end

        assign readdata      = d1;
        assign readdatavalid = v1;
    end else begin : g_lat1
        assign readdata      = d0;
        assign readdatavalid = v0;
    end

endmodule

// File: rtl/onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slaves on one clock.
// Optional post-reset clear engine: define ONCHIP_MEMORY_DP_CLEAR_EN.
module onchip_memory_dp
    import onchip_memory_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = "onchip_memory_dp.hex",
    localparam int unsigned ADDR_W      = addr_width(DEPTH),
    localparam int unsigned BE_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic              s1_waitrequest,
    input  logic [ADDR_W-1:0] s2_address,
    input  logic              s2_chipselect,
    input  logic              s2_read,
    input  logic              s2_write,
    input  logic [BE_W-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0] s2_writedata,
    output logic [DATA_W-1:0] s2_readdata,
    output logic              s2_readdatavalid,
    output logic              s2_waitrequest
);

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("onchip_memory_dp: READ_LATENCY must be 1 or 2");
    end

    // Preload from INIT_FILE is attached by the implementation flow; only the name lives here.
    localparam bit unused_init_file = (INIT_FILE != "");

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wait_r;
    logic              port_en;
    logic              s1_acc;
    logic              s1_acc_wr;
    logic              s1_acc_rd;
    logic              s2_acc;
    logic              s2_acc_wr;
    logic              s2_acc_rd;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [BE_W-1:0]   a_be;
    logic [DATA_W-1:0] a_data;
    logic [BE_W-1:0]   b_be;

    assign port_en   = clken & ~reset_req;
    assign s1_acc    = s1_chipselect & (s1_read | s1_write) & ~wait_r & port_en;
    assign s1_acc_wr = s1_acc & s1_write;
    assign s1_acc_rd = s1_acc & ~s1_write;
    assign s2_acc    = s2_chipselect & (s2_read | s2_write) & ~wait_r & port_en;
    assign s2_acc_wr = s2_acc & s2_write;
    assign s2_acc_rd = s2_acc & ~s2_write;

`ifdef ONCHIP_MEMORY_DP_CLEAR_EN
    clr_state_e        state_q;
    clr_state_e        state_d;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [ADDR_W-1:0] clr_addr_d;
    logic              wait_d;
    logic              clr_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CLR_IDLE;
            clr_addr_q <= '0;
            wait_r     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wait_r     <= wait_d;
        end
    end

    // IDLE already issues word 0 so the sweep spans exactly DEPTH enabled cycles.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wait_d     = wait_r;
        clr_we     = 1'b0;
        case (state_q)
            CLR_IDLE, CLR_CLEAR: begin
                if (port_en) begin
                    clr_we = 1'b1;
                    if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = CLR_DONE;
                        wait_d  = 1'b0;
                    end else begin
                        state_d    = CLR_CLEAR;
                        clr_addr_d = clr_addr_q + ADDR_W'(1);
                    end
                end
            end
            CLR_DONE: begin
                state_d = CLR_DONE;
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase
    end

    assign a_we   = clr_we | s1_acc_wr;
    assign a_addr = clr_we ? clr_addr_q : s1_address;
    assign a_be   = clr_we ? {BE_W{1'b1}} : s1_byteenable;
    assign a_data = clr_we ? '0 : s1_writedata;
`else
    assign wait_r = 1'b0;
    assign a_we   = s1_acc_wr;
    assign a_addr = s1_address;
    assign a_be   = s1_byteenable;
    assign a_data = s1_writedata;
`endif

    // Port B loses any lane that port A also writes at the same address.
    always_comb begin
        b_be = '0;
        if (s2_acc_wr) begin
            b_be = s2_byteenable;
            if (a_we && (a_addr == s2_address)) begin
                b_be = s2_byteenable & ~a_be;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (a_we && a_be[i]) begin
                mem[a_addr][i*8 +: 8] <= a_data[i*8 +: 8];
            end
            if (b_be[i]) begin
                mem[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
            end
        end
    end

    assign s1_waitrequest = wait_r;
    assign s2_waitrequest = wait_r;

    onchip_memory_rdpipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_s1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .accept        (s1_acc_rd),
        .ram_data      (mem[s1_address]),
        .readdata      (s1_readdata),
        .readdatavalid (s1_readdatavalid)
    );

    onchip_memory_rdpipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_s2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .accept        (s2_acc_rd),
        .ram_data      (mem[s2_address]),
        .readdata      (s2_readdata),
        .readdatavalid (s2_readdatavalid)
    );

endmodule

// File: doc/onchip_memory_dp.md
Name: onchip_memory_dp

Overview:
Parametrised true dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2) sharing one clock. It succeeds the fixed 4-word single-port memory. Width, depth, read latency and init file are generic, and the block adds readdatavalid pipelining, same-address write arbitration and an optional post-reset clear engine. It sits on the SoC interconnect as CPU data memory or CPU/peripheral shared buffer.

Parameters:
DATA_W, 32, data width in bits; multiple of 8.
DEPTH, 1024, words per port; power of two, at least 4.
ADDR_W, $clog2(DEPTH), word address width; derived, not overridden.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; 1 or 2 only.
INIT_FILE, "onchip_memory_dp.hex", initial contents; ignored when the clear engine is compiled in.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clken  in  1  global clock enable; 0 freezes all state
reset_req  in  1  1 blocks RAM access, same as clken=0 for the array only
s1_address  in  ADDR_W  word address
s1_chipselect  in  1  slave select
s1_read  in  1  read strobe
s1_write  in  1  write strobe
s1_byteenable  in  DATA_W/8  byte lane enables
s1_writedata  in  DATA_W  write data
s1_readdata  out  DATA_W  read data
s1_readdatavalid  out  1  read data valid
s1_waitrequest  out  1  stall
s2_*  same set as s1_*, independent port

Behaviour:
- Reset (reset_n=0, asynchronous): all readdata=0, readdatavalid=0, latency pipeline flushed. waitrequest=0 without the clear engine. RAM contents are not reset.
- Accept condition: chipselect & (read|write) & ~waitrequest & clken & ~reset_req. read and write asserted together on one port is illegal. Write takes priority and the read is dropped.
- Write: bytes with byteenable=1 are updated at the accepting edge. byteenable=0 bytes are unchanged. byteenable all-zero is a no-op that is still accepted.
- Read, READ_LATENCY=1: data is presented on the edge after acceptance, with readdatavalid high for exactly 1 cycle.
- Read, READ_LATENCY=2: an extra output register is added and readdatavalid is delayed to match. Back-to-back reads give a one-per-cycle valid stream.
- readdata holds its last value when readdatavalid=0.
- Same-port read-during-write cannot occur (single strobe).
- Cross-port read-during-write to the same address returns OLD data.
- Both ports write the same address in the same cycle: s1 wins for each byte lane both enable. Lanes enabled by only one port take that port's data.
- clken=0: the RAM, output registers and valid pipeline all hold. Accepted-but-unreturned reads complete once clken returns.
- reset_req=1: no new accesses are accepted. The in-flight pipeline still drains while clken=1.
- Address wrap: not applicable, because the address is exactly ADDR_W bits.
- Reset mid-read: the pending readdatavalid is lost. The master must reissue.

Optional Feature:
Macro ONCHIP_MEMORY_DP_CLEAR_EN.
Defined:
- A clear FSM (IDLE → CLEAR → DONE) starts on reset deassertion.
- CLEAR writes 0 to one word per clken cycle through port A, from address 0 up to DEPTH-1.
- Both waitrequest outputs are held at 1 from reset until the cycle after the last word is written, i.e. DEPTH clken-cycles.
- DONE is held until the next reset.
Undefined:
- No FSM exists and waitrequest is tied to 0.
- Contents come from INIT_FILE.

Decomposition:
Shared package onchip_memory_pkg holds:
- clear FSM state enum (IDLE/CLEAR/DONE)
- a function computing ADDR_W from DEPTH
- the READ_LATENCY legality check constant
Natural sub-module: onchip_memory_rdpipe, the per-port readdata/readdatavalid latency pipeline, instantiated twice.

Test Plan:
- s1 write 0xDEADBEEF to addr 5 with byteenable 0xF, then read addr 5 at READ_LATENCY=1 → readdata=0xDEADBEEF with readdatavalid exactly 1 cycle after acceptance.
- addr 7 holds 0x11223344. s1 writes 0xAABBCCDD with byteenable 0x5 → read gives 0x11BB33DD.
- Same cycle: s1 writes 0x000000AA with byteenable 0x1, s2 writes 0x0000BBCC with byteenable 0x3, both to addr 3 → read gives 0x0000BBAA.
- addr 9 holds 0x1. s2 reads addr 9 while s1 writes 0x2 to it in the same cycle → s2 returns 0x1 and a later read returns 0x2.
- READ_LATENCY=2: s1 issues 4 back-to-back reads of addresses 0–3 → 4 consecutive valid cycles starting 2 cycles after the first acceptance, data in order. Drop clken for 3 cycles mid-stream → valids pause and then resume, none lost.
- With ONCHIP_MEMORY_DP_CLEAR_EN and DEPTH=16 → waitrequest stays high for 16 cycles after reset_n rises, then any read returns 0. Asserting reset_n=0 mid-clear restarts the clear from address 0.
